// File: rtl/ingress_dest_scheduler_pkg.sv
// Shared types for the NMU ingress destination scheduler: FSM states and drop-reason codes.
package nmu_ingress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } sched_state_t;

    localparam logic [1:0] DROP_NONE     = 2'd0;
    localparam logic [1:0] DROP_ROUTE    = 2'd1;
    localparam logic [1:0] DROP_DISABLED = 2'd2;
    localparam logic [1:0] DROP_TIMEOUT  = 2'd3;

endpackage

// File: rtl/ingress_dest_scheduler_sat_counter.sv
// Saturating event counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ingress_dest_scheduler.sv
// Routes filtered ingress packets to per-application channels by tdest, dropping packets
// that cannot be routed, target disabled/faulted destinations, or stall past the timeout.
module ingress_dest_scheduler
    import nmu_ingress_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32,
    parameter int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
    parameter int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic [AXIS_ID_WIDTH:0]    axis_in_tdest,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic [NUM_AXIS_ID-1:0]    axis_out_tvalid,
    input  logic [NUM_AXIS_ID-1:0]    axis_out_tready,
    input  logic [NUM_AXIS_ID-1:0]    dest_enable,
    output logic [NUM_AXIS_ID-1:0]    dest_abort,
    output logic [NUM_AXIS_ID-1:0]    dest_fault,
    input  logic [NUM_AXIS_ID-1:0]    fault_clear,
    output logic [CNT_WIDTH-1:0]      cnt_drop_route,
    output logic [CNT_WIDTH-1:0]      cnt_drop_disabled,
    output logic [CNT_WIDTH-1:0]      cnt_drop_timeout
);

    localparam int STALL_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    sched_state_t               r_state;
    sched_state_t               w_next_state;
    logic [AXIS_ID_WIDTH-1:0]   r_dest;
    logic [STALL_W-1:0]         r_stall;
    logic [NUM_AXIS_ID-1:0]     r_fault;
    logic [NUM_AXIS_ID-1:0]     r_abort;

    logic [AXIS_ID_WIDTH-1:0]   w_in_dest;
    logic                       w_route_err;
    logic                       w_dest_ok;
    logic                       w_timeout;
    logic                       w_new_ready;
    logic                       w_cur_ready;
    logic [NUM_AXIS_ID-1:0]     w_valid_vec;
    logic                       w_ready;
    logic [NUM_AXIS_ID-1:0]     w_fault_set;
    logic [1:0]                 w_drop_reason;
    logic                       w_stall_inc;
    logic                       w_stall_clr;
    logic                       w_latch_dest;

    assign w_route_err = axis_in_tdest[AXIS_ID_WIDTH];
    assign w_in_dest   = axis_in_tdest[AXIS_ID_WIDTH-1:0];
    assign w_dest_ok   = dest_enable[w_in_dest] && !r_fault[w_in_dest];
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_stall == STALL_LIMIT);
    assign w_new_ready = axis_out_tready[w_in_dest];
    assign w_cur_ready = axis_out_tready[r_dest];

    always_comb begin
        w_next_state  = r_state;
        w_valid_vec   = '0;
        w_ready       = 1'b0;
        w_fault_set   = '0;
        w_drop_reason = DROP_NONE;
        w_stall_inc   = 1'b0;
        w_stall_clr   = 1'b0;
        w_latch_dest  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (axis_in_tvalid) begin
                    if (w_route_err || !w_dest_ok || w_timeout) begin
                        w_ready       = 1'b1;
                        w_stall_clr   = 1'b1;
                        w_next_state  = axis_in_tlast ? ST_IDLE : ST_DROP;
                        w_drop_reason = w_route_err ? DROP_ROUTE :
                                        (!w_dest_ok ? DROP_DISABLED : DROP_TIMEOUT);
                    end else begin
                        w_valid_vec[w_in_dest] = 1'b1;
                        w_ready                = w_new_ready;
                        if (w_new_ready) begin
                            w_stall_clr  = 1'b1;
                            w_latch_dest = 1'b1;
                            w_next_state = axis_in_tlast ? ST_IDLE : ST_FWD;
                        end else begin
                            w_stall_inc = 1'b1;
                        end
                    end
                end
            end

            ST_FWD: begin
                if (axis_in_tvalid) begin
                    // Destination stalled mid-packet: truncate it and quarantine the channel.
                    if (w_timeout) begin
                        w_ready             = 1'b1;
                        w_stall_clr         = 1'b1;
                        w_fault_set[r_dest] = 1'b1;
                        w_drop_reason       = DROP_TIMEOUT;
                        w_next_state        = axis_in_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        w_valid_vec[r_dest] = 1'b1;
                        w_ready             = w_cur_ready;
                        if (w_cur_ready) begin
                            w_stall_clr = 1'b1;
                            if (axis_in_tlast) begin
                                w_next_state = ST_IDLE;
                            end
                        end else begin
                            w_stall_inc = 1'b1;
                        end
                    end
                end
            end

            ST_DROP: begin
                w_ready = 1'b1;
                if (axis_in_tvalid && axis_in_tlast) begin
                    w_stall_clr  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
            r_stall <= '0;
            r_fault <= '0;
            r_abort <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_dest) begin
                r_dest <= w_in_dest;
            end
            if (w_stall_clr) begin
                r_stall <= '0;
            end else if (w_stall_inc && (TIMEOUT_CYCLES != 0)) begin
                r_stall <= r_stall + STALL_W'(1);
            end
            r_fault <= (r_fault & ~fault_clear) | w_fault_set;
            r_abort <= w_fault_set;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_route (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_inc   (w_drop_reason == DROP_ROUTE),
        .o_count (cnt_drop_route)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_disabled (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_inc   (w_drop_reason == DROP_DISABLED),
        .o_count (cnt_drop_disabled)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_timeout (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_inc   (w_drop_reason == DROP_TIMEOUT),
        .o_count (cnt_drop_timeout)
    );

    assign axis_in_tready  = w_ready;
    assign axis_out_tdata  = axis_in_tdata;
    assign axis_out_tkeep  = axis_in_tkeep;
    assign axis_out_tlast  = axis_in_tlast;
    assign axis_out_tvalid = w_valid_vec;
    assign dest_abort      = r_abort;
    assign dest_fault      = r_fault;

endmodule

// File: doc/ingress_dest_scheduler.md
Name: ingress_dest_scheduler

Overview:
Sits directly after the ingress filtering stage in the NMU ingress path and delivers each filtered packet to one of NUM_AXIS_ID per-application output channels, chosen by the packet's tdest. It guards the shared ingress pipe against head-of-line blocking: it drops packets for error or disabled destinations, and drops packets whose destination stalls past a timeout. It quarantines a destination that stalls mid-packet and exposes saturating drop counters for the control plane.

Parameters:
AXIS_BUS_WIDTH, 64, data width in bits; NUM_BUS_BYTES = AXIS_BUS_WIDTH/8
AXIS_ID_WIDTH, 4, destination index width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH
TIMEOUT_CYCLES, 1024, consecutive stalled cycles before a drop or quarantine; 0 disables timeouts
CNT_WIDTH, 32, width of each drop counter

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
axis_in_tdata  in  AXIS_BUS_WIDTH  data from the filtering stage
axis_in_tkeep  in  NUM_BUS_BYTES  byte enables
axis_in_tlast  in  1  end of packet
axis_in_tdest  in  AXIS_ID_WIDTH+1  destination; MSB=1 means no valid route
axis_in_tvalid  in  1  input valid
axis_in_tready  out  1  input ready
axis_out_tdata  out  AXIS_BUS_WIDTH  shared data, driven from axis_in_tdata
axis_out_tkeep  out  NUM_BUS_BYTES  shared byte enables
axis_out_tlast  out  1  shared last
axis_out_tvalid  out  NUM_AXIS_ID  one-hot per-destination valid
axis_out_tready  in  NUM_AXIS_ID  per-destination ready
dest_enable  in  NUM_AXIS_ID  control plane: destination i may receive packets
dest_abort  out  NUM_AXIS_ID  one-cycle pulse: packet in flight to i was truncated
dest_fault  out  NUM_AXIS_ID  sticky quarantine flag per destination
fault_clear  in  NUM_AXIS_ID  one-cycle pulse clears the matching dest_fault bit
cnt_drop_route  out  CNT_WIDTH  packets dropped because tdest MSB was set
cnt_drop_disabled  out  CNT_WIDTH  packets dropped because the destination was disabled or faulted
cnt_drop_timeout  out  CNT_WIDTH  packets dropped or truncated by timeout

Behaviour:
- Reset values (async assert, sync release): FSM=IDLE, stall counter=0, dest_fault=0, all counters=0, dest_abort=0. Output valids are 0 because the FSM is in IDLE with no input valid.
- FSM states are IDLE, FWD, DROP.
- IDLE, on axis_in_tvalid, evaluates the first beat combinationally:
  - MSB set: drop the beat (tready=1), cnt_drop_route++.
  - Otherwise, if !dest_enable[d] or dest_fault[d]: drop the beat, cnt_drop_disabled++.
  - Otherwise: present the beat to destination d (axis_out_tvalid[d]=1, axis_in_tready=axis_out_tready[d]) and latch d.
  - Transitions: a dropped beat with tlast=0 goes to DROP. An accepted beat with tlast=0 goes to FWD. A beat with tlast=1 stays in IDLE.
- First-beat timeout: while the first beat waits in IDLE for the chosen d, the stall counter increments each cycle with tready=0. When it reaches TIMEOUT_CYCLES:
  - That cycle, drop the beat: tready=1, out tvalid=0, cnt_drop_timeout++.
  - Go to DROP (or stay in IDLE if tlast=1).
  - d is not faulted.
- FWD: route every beat to the latched d; tdest is ignored mid-packet.
  - An accepted tlast beat returns the FSM to IDLE.
  - The stall counter counts cycles with valid=1 and ready=0; it resets on each accepted beat and whenever the FSM enters IDLE.
- Mid-packet timeout (FWD, counter reaches TIMEOUT_CYCLES):
  - Set dest_fault[d] and pulse dest_abort[d] for one cycle.
  - cnt_drop_timeout++.
  - Drop the current beat and go to DROP, or to IDLE if that beat has tlast.
- Clearing dest_enable[d] in FWD does not abort the packet; it takes effect at the next packet start.
- DROP: tready=1, all out valids=0; exit to IDLE on a tlast beat.
- All three counters saturate at all-ones.
- fault_clear and a same-cycle fault set on the same bit: the set wins.
- Latency is zero: data and valid pass combinationally; only the control state is registered.
- Input valid low: all out valids=0 and the stall counter holds its value.
- Reset asserted mid-packet: the downstream packet is left truncated with no abort pulse. Downstream resets together with this block.

Decomposition:
- Package nmu_ingress_pkg holds the FSM state enum (sched_state_t) and drop-reason encoding constants.
- Sub-module sat_counter (width parameter, increment input, saturating) is instantiated three times.

Test Plan:
- tdest=3, dest_enable[3]=1, ready high, 4-beat packet → axis_out_tvalid=4'b1000 pattern on channel 3, all beats delivered, zero latency, counters stay 0.
- tdest=5'b10000, 3-beat packet → tready=1 every cycle, no out valid, cnt_drop_route=1.
- dest_enable[2]=0, tdest=2, 2 packets → both dropped, cnt_drop_disabled=2; re-enable → next packet delivered.
- TIMEOUT_CYCLES=8, tdest=1, ready[1]=0 → first beat dropped on cycle 8 and the rest of the packet discarded; cnt_drop_timeout=1; dest_fault[1]=0; next packet to 1 with ready high is delivered.
- TIMEOUT_CYCLES=8, ready[4] drops after beat 2 of 5 → dest_abort[4] pulses once, dest_fault[4]=1, cnt_drop_timeout=1. A following packet to 4 is dropped as disabled. fault_clear[4] plus a new packet → delivered.
- cnt_drop_route preloaded near max via back-to-back error packets (CNT_WIDTH=4, 20 packets) → counter holds 4'hF; aresetn asserted mid-FWD → FSM=IDLE and outputs 0 asynchronously.
